fir_io_ctrl: RTL and testbench

FIR_IO_CTRL -- requirements
Module: fir_io_ctrl

---
 rtl/fir_io_ctrl.sv | 112 +++++++++++
 tb/tb_fir_io_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_io_ctrl.sv
// I/O controller for a free-running FIR PE chain: coefficient tap shift register,
// zero-stuffed sample injection, latency token tracking and an in-order result FIFO.
module fir_io_ctrl #(
  parameter int NTAP  = 8,
  parameter int LAT   = 10,
  parameter int DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              coef_we_i,
  input  logic [7:0]        coef_data_i,
  output logic [8*NTAP-1:0] coef_bus_o,
  output logic              coef_err_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [7:0]        in_data_i,
  output logic [7:0]        chain_x_o,
  input  logic [15:0]       chain_y_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [15:0]       out_data_o,
  output logic [15:0]       bubble_cnt_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + LAT + 2);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(DEPTH);

  logic [7:0]        chain_x_q, chain_x_d;
  logic [8*NTAP-1:0] coef_q, coef_d;
  logic              coef_err_q, coef_err_d;
  logic [LAT:0]      tok_q, tok_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [15:0]       bubble_q, bubble_d;
  logic [15:0]       mem_q [DEPTH];

  logic accept, push, pop, coef_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // tok_q[0] marks a real sample sitting in chain_x; tok_q[LAT] marks that
  // sample's result present on chain_y this cycle, so it is pushed on this edge.
  assign push    = tok_q[LAT];
  assign pop     = out_valid_o && out_ready_i;
  assign accept  = in_valid_i && in_ready_o;
  assign coef_ok = coef_we_i && (inflight_q == '0);

  assign in_ready_o   = !rst_i && ((inflight_q + fifo_cnt_q) < CNT_LIMIT);
  assign out_valid_o  = (fifo_cnt_q != '0);
  assign out_data_o   = mem_q[rd_ptr_q];
  assign chain_x_o    = chain_x_q;
  assign coef_bus_o   = coef_q;
  assign coef_err_o   = coef_err_q;
  assign bubble_cnt_o = bubble_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    chain_x_d  = accept ? in_data_i : 8'h00;
    tok_d      = {tok_q[LAT-1:0], accept};
    inflight_d = inflight_q + CW'(accept) - CW'(push);
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    coef_d     = coef_q;
    coef_err_d = coef_err_q;
    bubble_d   = bubble_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (coef_ok) coef_d = {coef_q[8*NTAP-9:0], coef_data_i};
    if (coef_we_i && (inflight_q != '0)) coef_err_d = 1'b1;
    if (!accept && (bubble_q != 16'hFFFF)) bubble_d = bubble_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_x_q  <= '0;
      coef_q     <= '0;
      coef_err_q <= 1'b0;
      tok_q      <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      bubble_q   <= '0;
    end else begin
      chain_x_q  <= chain_x_d;
      coef_q     <= coef_d;
      coef_err_q <= coef_err_d;
      tok_q      <= tok_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      bubble_q   <= bubble_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; fifo_cnt_q gates every
  // read, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= chain_y_i;
  end

endmodule

// File: tb/tb_fir_io_ctrl.sv
// Self-checking bench for fir_io_ctrl; the PE chain is modelled as
// chain_y(k) = 3 * chain_x(k - LAT), results are scoreboarded in sample order.
module tb_fir_io_ctrl;
  localparam int NTAP  = 8;
  localparam int LAT   = 10;
  localparam int DEPTH = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              coef_we_i = 1'b0;
  logic [7:0]        coef_data_i = '0;
  logic [8*NTAP-1:0] coef_bus_o;
  logic              coef_err_o;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [7:0]        in_data_i = '0;
  logic [7:0]        chain_x_o;
  logic [15:0]       chain_y_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [15:0]       out_data_o;
  logic [15:0]       bubble_cnt_o;

  fir_io_ctrl #(.NTAP(NTAP), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .coef_we_i(coef_we_i), .coef_data_i(coef_data_i),
    .coef_bus_o(coef_bus_o), .coef_err_o(coef_err_o), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .in_data_i(in_data_i), .chain_x_o(chain_x_o),
    .chain_y_i(chain_y_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0]        xhist[$];
  logic [7:0]        sent[$];
  logic [15:0]       got[$];
  logic [15:0]       bub_model = '0;
  logic [8*NTAP-1:0] exp_bus = '0;

  // Behavioural PE chain: output is three times the chain input LAT cycles ago.
  initial for (int i = 0; i < LAT; i++) xhist.push_back(8'h00);
  always @(posedge clk_i) begin
    #1;
    xhist.push_back(chain_x_o);
    if (xhist.size() > LAT + 1) void'(xhist.pop_front());
    chain_y_i = 16'(xhist[0]) * 16'd3;
  end

  // One clock: record handshake transfers and idle cycles, then advance.
  task automatic tick();
    if (rst_i) bub_model = '0;
    else begin
      if (in_valid_i && in_ready_o) sent.push_back(in_data_i);
      else if (bub_model != 16'hFFFF) bub_model++;
      if (out_valid_o && out_ready_i) got.push_back(out_data_o);
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    in_valid_i = 1'b0; coef_we_i = 1'b0;
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    sent.delete(); got.delete();
    #1;
  endtask

  task automatic drain(input int n, output bit ok);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    for (int i = 0; i < 200 && got.size() < n; i++) tick();
    ok = (got.size() >= n);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; coef_we_i = 1'b1; coef_data_i = 8'hA5;
    in_valid_i = 1'b1; in_data_i = 8'h55; out_ready_i = 1'b1;
    tick(); tick(); tick();
    total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready_o); end
    total++; if (coef_bus_o !== '0) begin bad++; $display("FAIL reset_coef_bus: got %h expected 0", coef_bus_o); end
    total++; if (coef_err_o !== 1'b0) begin bad++; $display("FAIL reset_coef_err: got %b expected 0", coef_err_o); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o); end
    total++; if (bubble_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_bubble: got %0d expected 0", bubble_cnt_o); end
    total++; if (chain_x_o !== 8'd0) begin bad++; $display("FAIL reset_chain_x: got %h expected 0", chain_x_o); end
    rst_i = 1'b0; coef_we_i = 1'b0; in_valid_i = 1'b0;
    sent.delete(); got.delete();
    #1;
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b expected 1", in_ready_o); end
  endtask

  task automatic test_coef_load();
    logic [7:0] vals [NTAP];
    logic [7:0] v, s;
    bit ok;
    // 8 first ... 1 last: the newest value lands in tap 0.
    coef_we_i = 1'b1;
    for (int i = 0; i < NTAP; i++) begin coef_data_i = 8'(NTAP - i); tick(); end
    coef_we_i = 1'b0;
    total++; if (coef_bus_o !== 64'h0807060504030201) begin bad++; $display("FAIL coef_load_seq: got %h expected 0807060504030201", coef_bus_o); end
    total++; if (coef_err_o !== 1'b0) begin bad++; $display("FAIL coef_load_err: got %b expected 0", coef_err_o); end
    coef_we_i = 1'b1;
    for (int i = 0; i < NTAP; i++) begin vals[i] = 8'($urandom); coef_data_i = vals[i]; tick(); end
    coef_we_i = 1'b0;
    for (int k = 0; k < NTAP; k++) exp_bus[8*k +: 8] = vals[NTAP-1-k];
    total++; if (coef_bus_o !== exp_bus) begin bad++; $display("FAIL coef_load_rand: got %h expected %h", coef_bus_o, exp_bus); end
    // Coefficient write and sample accepted together.
    v = 8'($urandom); s = 8'($urandom);
    coef_we_i = 1'b1; coef_data_i = v; in_valid_i = 1'b1; in_data_i = s;
    tick();
    coef_we_i = 1'b0; in_valid_i = 1'b0;
    exp_bus[7:0] = v;
    for (int k = 1; k < NTAP; k++) exp_bus[8*k +: 8] = vals[NTAP-k];
    total++; if (coef_bus_o !== exp_bus) begin bad++; $display("FAIL coef_with_sample: got %h expected %h", coef_bus_o, exp_bus); end
    total++; if (sent.size() !== 1) begin bad++; $display("FAIL sample_with_coef: got %0d accepted expected 1", sent.size()); end
    drain(1, ok);
    total++; if (!ok || got[0] !== 16'(s) * 16'd3) begin bad++; $display("FAIL sample_with_coef_result: got %0d expected %0d", ok ? got[0] : 16'hxxxx, 16'(s) * 16'd3); end
    sent.delete(); got.delete();
  endtask

  task automatic test_stream();
    int c0 = -1, first_v = -1;
    logic [15:0] first_d = '0;
    bit lost = 0, bub_moved = 0;
    logic [15:0] bub_exp;
    do_reset();
    out_ready_i = 1'b1;
    tick(); tick(); tick();
    bub_exp = 16'd3;
    for (int i = 0; i < 120 && got.size() < 20; i++) begin
      if (i < 20) begin
        in_valid_i = 1'b1; in_data_i = 8'(i + 1);
        if (!in_ready_o) lost = 1;
        if (bubble_cnt_o !== bub_exp) bub_moved = 1;
        if (c0 < 0) c0 = cyc;
      end else in_valid_i = 1'b0;
      if (out_valid_o && first_v < 0) begin first_v = cyc; first_d = out_data_o; end
      tick();
    end
    total++; if (lost || sent.size() !== 20) begin bad++; $display("FAIL stream_accept: got %0d accepted expected 20", sent.size()); end
    total++; if (bub_moved) begin bad++; $display("FAIL stream_bubble: bubble count moved during stream, expected %0d", bub_exp); end
    total++; if (first_v - c0 !== LAT + 2) begin bad++; $display("FAIL stream_latency: got %0d expected %0d", first_v - c0, LAT + 2); end
    total++; if (first_d !== 16'd3) begin bad++; $display("FAIL stream_first: got %0d expected 3", first_d); end
    total++; if (got.size() !== 20) begin bad++; $display("FAIL stream_count: got %0d expected 20", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      total++; if (got[i] !== 16'(3 * (i + 1))) begin bad++; $display("FAIL stream_data[%0d]: got %0d expected %0d", i, got[i], 3 * (i + 1)); end
    end
    sent.delete(); got.delete();
  endtask

  task automatic test_back_to_back_stall();
    bit late_ready = 0, unstable = 0, held = 0, ok;
    logic [15:0] head = '0;
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data_i = 8'($urandom);
      if (i >= 30 && in_ready_o) late_ready = 1;
      if (out_valid_o) begin
        if (held && out_data_o !== head) unstable = 1;
        head = out_data_o; held = 1;
      end
      tick();
    end
    total++; if (sent.size() !== DEPTH) begin bad++; $display("FAIL stall_accepted: got %0d expected %0d", sent.size(), DEPTH); end
    total++; if (late_ready) begin bad++; $display("FAIL stall_ready: got in_ready 1 expected 0 once full"); end
    total++; if (unstable || !held) begin bad++; $display("FAIL stall_hold: head not held stable under backpressure, held=%0d", held); end
    drain(DEPTH, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_drain: got %0d results expected %0d", got.size(), DEPTH); end
    for (int i = 0; i < got.size() && i < sent.size(); i++) begin
      total++; if (got[i] !== 16'(sent[i]) * 16'd3) begin bad++; $display("FAIL stall_data[%0d]: got %0d expected %0d", i, got[i], 16'(sent[i]) * 16'd3); end
    end
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL stall_ready_back: got %b expected 1", in_ready_o); end
    sent.delete(); got.delete();
  endtask

  task automatic test_coef_err();
    bit ok;
    logic [7:0] s = 8'($urandom);
    in_valid_i = 1'b1; in_data_i = s;
    tick();
    in_valid_i = 1'b0;
    tick();
    coef_we_i = 1'b1; coef_data_i = 8'($urandom);
    tick();
    coef_we_i = 1'b0;
    total++; if (coef_bus_o !== exp_bus) begin bad++; $display("FAIL err_taps_held: got %h expected %h", coef_bus_o, exp_bus); end
    total++; if (coef_err_o !== 1'b1) begin bad++; $display("FAIL err_set: got %b expected 1", coef_err_o); end
    drain(1, ok);
    total++; if (!ok || got[0] !== 16'(s) * 16'd3) begin bad++; $display("FAIL err_result: got %0d expected %0d", ok ? got[0] : 16'hxxxx, 16'(s) * 16'd3); end
    for (int i = 0; i < 5; i++) tick();
    total++; if (coef_err_o !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b expected 1", coef_err_o); end
    do_reset();
    exp_bus = '0;
    total++; if (coef_err_o !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b expected 0", coef_err_o); end
  endtask

  task automatic test_reset_mid();
    bit leak = 0;
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin in_data_i = 8'($urandom_range(1, 255)); tick(); end
    in_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    total++; if (out_valid_o !== 1'b1 || sent.size() !== 8) begin bad++; $display("FAIL mid_setup: got out_valid %b sent %0d expected 1 and 8", out_valid_o, sent.size()); end
    do_reset();
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b expected 0", out_valid_o); end
    out_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid_o) leak = 1;
      tick();
    end
    total++; if (leak || got.size() !== 0) begin bad++; $display("FAIL mid_stale: got %0d stale results expected 0", got.size()); end
    total++; if (bubble_cnt_o !== 16'd40) begin bad++; $display("FAIL mid_bubble: got %0d expected 40", bubble_cnt_o); end
  endtask

  task automatic test_random();
    int ready_err = 0, data_err = 0;
    bit ok;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      in_valid_i  = ($urandom_range(0, 9) < 7);
      in_data_i   = 8'($urandom);
      out_ready_i = ($urandom_range(0, 9) < 5);
      // Every accepted-but-unpopped sample is either in the chain or queued.
      if (in_ready_o !== ((sent.size() - got.size()) < DEPTH)) ready_err++;
      tick();
    end
    drain(sent.size(), ok);
    total++; if (ready_err != 0) begin bad++; $display("FAIL rand_ready: got %0d cycles with wrong in_ready expected 0", ready_err); end
    total++; if (!ok || got.size() !== sent.size()) begin bad++; $display("FAIL rand_count: got %0d expected %0d", got.size(), sent.size()); end
    for (int i = 0; i < got.size() && i < sent.size(); i++)
      if (got[i] !== 16'(sent[i]) * 16'd3) data_err++;
    total++; if (data_err != 0) begin bad++; $display("FAIL rand_data: got %0d wrong results expected 0", data_err); end
    total++; if (bubble_cnt_o !== bub_model) begin bad++; $display("FAIL rand_bubble: got %0d expected %0d", bubble_cnt_o, bub_model); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 65534; i++) tick();
    total++; if (bubble_cnt_o !== 16'hFFFE) begin bad++; $display("FAIL sat_before: got %h expected fffe", bubble_cnt_o); end
    tick();
    total++; if (bubble_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL sat_reach: got %h expected ffff", bubble_cnt_o); end
    for (int i = 0; i < 4465; i++) tick();
    total++; if (bubble_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h expected ffff", bubble_cnt_o); end
  endtask

  initial begin
    #1;
    test_reset();
    test_coef_load();
    test_stream();
    test_back_to_back_stall();
    test_coef_load();
    test_coef_err();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
